// File: rtl/mem_responder_pkg.sv
// Shared constants for the memory responder: default widths, MMIO window
// addresses and console status bit positions.
package mem_responder_pkg;

    localparam int MEM_WIDTH      = 32;
    localparam int MEM_ADDR_WIDTH = 8;

    // Byte addresses of the MMIO window (only decoded when MEM_MMIO_EN is set)
    localparam logic [7:0] MEM_CON_TX_ADDR   = 8'hF0;
    localparam logic [7:0] MEM_CON_STAT_ADDR = 8'hF4;
    localparam logic [7:0] MEM_CNT_ADDR      = 8'hF8;
    localparam logic [7:0] MEM_RSVD_ADDR     = 8'hFC;

    // Console status register layout
    localparam int STAT_OVF_BIT   = 7;
    localparam int STAT_FULL_BIT  = 6;
    localparam int STAT_EMPTY_BIT = 5;
    localparam int STAT_CNT_LSB   = 0;
    localparam int STAT_CNT_W     = 3;

    // Window register select; the encoding equals byte address bits [3:2]
    typedef enum logic [1:0] {
        MMIO_CON_TX   = MEM_CON_TX_ADDR[3:2],
        MMIO_CON_STAT = MEM_CON_STAT_ADDR[3:2],
        MMIO_CNT      = MEM_CNT_ADDR[3:2],
        MMIO_RSVD     = MEM_RSVD_ADDR[3:2]
    } mmio_sel_e;

endpackage

// File: rtl/mem_responder_if.sv
// Core-side memory bus plus console drain port of the memory responder.
interface mem_responder_if
    import mem_responder_pkg::*;
#(
    parameter int WIDTH      = MEM_WIDTH,
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH
);
    logic                  memread_i;
    logic                  memwrite_i;
    logic [ADDR_WIDTH-1:0] memaddr_i;
    logic [WIDTH-1:0]      memwdata_i;
    logic [WIDTH-1:0]      memrdata_o;
    logic                  misalign_o;
    logic                  con_valid_o;
    logic [7:0]            con_data_o;
    logic                  con_ready_i;

    modport master (
        output memread_i, memwrite_i, memaddr_i, memwdata_i, con_ready_i,
        input  memrdata_o, misalign_o, con_valid_o, con_data_o
    );

    modport slave (
        input  memread_i, memwrite_i, memaddr_i, memwdata_i, con_ready_i,
        output memrdata_o, misalign_o, con_valid_o, con_data_o
    );
endinterface

// File: rtl/mem_responder_con_fifo.sv
// Console transmit FIFO: synchronous, registered wrap-bit pointers,
// a push into a full FIFO is accepted only when a pop happens in the same cycle.
module con_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [W-1:0]             data_i,
    input  logic                     pop_i,
    output logic [W-1:0]             data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    // Accept/advance decisions for both pointers
    always_comb begin
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full_o || do_pop);
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    end

    // Pointer registers; reset empties the FIFO and discards a same-cycle push
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset; readers gate the head with empty
    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end
endmodule

// File: rtl/mem_responder.sv
// Single-port word RAM answering the core's memread/memwrite requests with
// one-cycle registered read data and read-before-write on collisions.
// Optional feature macro MEM_MMIO_EN: maps console FIFO, console status and
// a free-running cycle counter at byte addresses 0xF0..0xFC.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int WIDTH      = MEM_WIDTH,
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus
);
    localparam int WORDS = 2 ** (ADDR_WIDTH - 2);

    logic [WIDTH-1:0]      ram_mem [WORDS];
    logic [ADDR_WIDTH-3:0] widx;
    logic                  access;
    logic                  in_window;
    logic                  ram_we;
    logic [WIDTH-1:0]      mmio_rdata;
    logic [WIDTH-1:0]      rdata_q, rdata_d;
    logic                  misalign_q, misalign_d;

    assign widx   = bus.memaddr_i[ADDR_WIDTH-1:2];
    assign access = bus.memread_i || bus.memwrite_i;

    // RAM array, contents survive reset
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_mem[widx] <= bus.memwdata_i;
        end
    end

    // Read-data mux and sticky misalignment flag; RAM is sampled before the write lands
    always_comb begin
        rdata_d    = rdata_q;
        misalign_d = misalign_q || (access && (bus.memaddr_i[1:0] != 2'b00));
        if (bus.memread_i) begin
            rdata_d = in_window ? mmio_rdata : ram_mem[widx];
        end
    end

    // Read-data and misalignment registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
        end
    end

    assign bus.memrdata_o = rdata_q;
    assign bus.misalign_o = misalign_q;

`ifdef MEM_MMIO_EN
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_WIDTH-1:0] WIN_BASE = ADDR_WIDTH'(MEM_CON_TX_ADDR);

    mmio_sel_e   sel;
    logic        push, pop;
    logic        fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [7:0]  fifo_head;
    logic [7:0]  stat;
    logic        ovf_q, ovf_d;
    logic [31:0] cnt_q, cnt_d;

    assign in_window = (bus.memaddr_i[ADDR_WIDTH-1:4] == WIN_BASE[ADDR_WIDTH-1:4]);
    assign sel       = mmio_sel_e'(bus.memaddr_i[3:2]);
    assign pop       = !fifo_empty && bus.con_ready_i;
    assign push      = bus.memwrite_i && in_window && (sel == MMIO_CON_TX);
    assign ram_we    = bus.memwrite_i && !in_window;

    con_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_con_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  (bus.memwdata_i[7:0]),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Window read mux, overflow tracking and counter next value
    always_comb begin
        stat                 = 8'h00;
        stat[STAT_OVF_BIT]   = ovf_q;
        stat[STAT_FULL_BIT]  = fifo_full;
        stat[STAT_EMPTY_BIT] = fifo_empty;
        stat[STAT_CNT_LSB +: STAT_CNT_W] = STAT_CNT_W'(fifo_count);

        mmio_rdata = '0;
        case (sel)
            MMIO_CON_STAT: mmio_rdata = WIDTH'(stat);
            MMIO_CNT:      mmio_rdata = WIDTH'(cnt_q);
            default:       mmio_rdata = '0;
        endcase

        ovf_d = ovf_q;
        if (bus.memread_i && in_window && (sel == MMIO_CON_STAT)) begin
            ovf_d = 1'b0;
        end
        if (push && fifo_full && !pop) begin
            ovf_d = 1'b1;
        end

        if (bus.memwrite_i && in_window && (sel == MMIO_CNT)) begin
            cnt_d = 32'(bus.memwdata_i);
        end else begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // Overflow flag and cycle counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            ovf_q <= ovf_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.con_valid_o = !fifo_empty;
    assign bus.con_data_o  = fifo_empty ? 8'h00 : fifo_head;
`else
    logic unused_con_ready;

    assign in_window        = 1'b0;
    assign mmio_rdata       = '0;
    assign ram_we           = bus.memwrite_i;
    assign bus.con_valid_o  = 1'b0;
    assign bus.con_data_o   = 8'h00;
    assign unused_con_ready = bus.con_ready_i;
`endif
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: vector table for RAM behaviour, hand sequences for
// misalignment, reset and (with MEM_MMIO_EN) the console FIFO and counter.
module tb_mem_responder;
    import mem_responder_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_responder_if #(.WIDTH(32), .ADDR_WIDTH(8)) bus ();

    mem_responder #(
        .WIDTH      (32),
        .ADDR_WIDTH (8),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit          rd;
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs [14];
    logic [31:0] ram_m [64];
    logic [31:0] exp_q [$];
    logic [7:0]  fifo_m [$];
    logic [31:0] last_rd;
    logic [31:0] cnt_m;
    bit          mis_m;
    bit          ovf_m;
    int          checks   = 0;
    int          failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] status_m();
        logic [31:0] s;
        s = 32'h0;
        s[7]   = ovf_m;
        s[6]   = (fifo_m.size() == DEPTH);
        s[5]   = (fifo_m.size() == 0);
        s[2:0] = 3'(fifo_m.size());
        return s;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, "_rdata"},    bus.memrdata_o, last_rd);
        check({tag, "_misalign"}, {31'b0, bus.misalign_o}, {31'b0, mis_m});
        check({tag, "_con_valid"}, {31'b0, bus.con_valid_o}, {31'b0, fifo_m.size() != 0});
        check({tag, "_con_data"}, {24'b0, bus.con_data_o},
              {24'b0, (fifo_m.size() != 0) ? fifo_m[0] : 8'h00});
    endtask

    // One bus cycle: drive, model the edge, compare just after it
    task automatic do_cycle(input bit rd, input bit wr, input logic [7:0] addr,
                            input logic [31:0] wd, input bit rdy,
                            input bit use_exp, input logic [31:0] texp);
        logic [5:0]  w;
        bit          win;
        bit          pop;
        logic [31:0] e;
        w   = addr[7:2];
        win = 1'b0;
`ifdef MEM_MMIO_EN
        win = (addr >= 8'hF0);
`endif
        bus.memread_i   = rd;
        bus.memwrite_i  = wr;
        bus.memaddr_i   = addr;
        bus.memwdata_i  = wd;
        bus.con_ready_i = rdy;
        if (rd) begin
            if (use_exp)       e = texp;
            else if (!win)     e = ram_m[w];
            else if (addr[3:2] == 2'b01) e = status_m();
            else if (addr[3:2] == 2'b10) e = cnt_m;
            else               e = 32'h0;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if ((rd || wr) && (addr[1:0] != 2'b00)) mis_m = 1'b1;
        if (wr && !win) ram_m[w] = wd;
`ifdef MEM_MMIO_EN
        pop = (fifo_m.size() != 0) && rdy;
        if (rd && win && addr[3:2] == 2'b01) ovf_m = 1'b0;
        if (pop) void'(fifo_m.pop_front());
        if (wr && win && addr[3:2] == 2'b00) begin
            if (fifo_m.size() < DEPTH) fifo_m.push_back(wd[7:0]);
            else ovf_m = 1'b1;
        end
        cnt_m = (wr && win && addr[3:2] == 2'b10) ? wd : cnt_m + 32'd1;
`else
        pop = 1'b0;
`endif
        if (rd) last_rd = exp_q.pop_front();
        check_outputs(rd ? "read" : "hold");
    endtask

    task automatic idle(input bit rdy);
        do_cycle(1'b0, 1'b0, 8'h00, 32'h0, rdy, 1'b0, 32'h0);
    endtask

    task automatic rd_a(input logic [7:0] addr);
        do_cycle(1'b1, 1'b0, addr, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic wr_a(input logic [7:0] addr, input logic [31:0] wd, input bit rdy);
        do_cycle(1'b0, 1'b1, addr, wd, rdy, 1'b0, 32'h0);
    endtask

    // Reset for one edge with arbitrary bus activity; all outputs must clear
    task automatic do_reset(input bit wr, input logic [7:0] addr, input logic [31:0] wd, input bit rdy);
        bus.memread_i   = 1'b0;
        bus.memwrite_i  = wr;
        bus.memaddr_i   = addr;
        bus.memwdata_i  = wd;
        bus.con_ready_i = rdy;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.memwrite_i  = 1'b0;
        bus.con_ready_i = 1'b0;
        mis_m   = 1'b0;
        ovf_m   = 1'b0;
        cnt_m   = 32'h0;
        last_rd = 32'h0;
        fifo_m.delete();
        exp_q.delete();
        check("reset_rdata",    bus.memrdata_o, 32'h0);
        check("reset_misalign", {31'b0, bus.misalign_o}, 32'h0);
        check("reset_con_valid", {31'b0, bus.con_valid_o}, 32'h0);
        check("reset_con_data", {24'b0, bus.con_data_o}, 32'h0);
    endtask

    initial begin
        vecs[0]  = '{rd:0, wr:1, addr:8'h10, wd:32'hDEADBEEF, exp:32'h0};
        vecs[1]  = '{rd:1, wr:0, addr:8'h10, wd:32'h0,        exp:32'hDEADBEEF};
        vecs[2]  = '{rd:0, wr:1, addr:8'h20, wd:32'h00000001, exp:32'h0};
        vecs[3]  = '{rd:1, wr:1, addr:8'h20, wd:32'h00000002, exp:32'h00000001};
        vecs[4]  = '{rd:1, wr:0, addr:8'h20, wd:32'h0,        exp:32'h00000002};
        vecs[5]  = '{rd:0, wr:1, addr:8'h04, wd:32'hA5A50F0F, exp:32'h0};
        vecs[6]  = '{rd:0, wr:1, addr:8'h08, wd:32'h12345678, exp:32'h0};
        vecs[7]  = '{rd:1, wr:0, addr:8'h04, wd:32'h0,        exp:32'hA5A50F0F};
        vecs[8]  = '{rd:1, wr:0, addr:8'h08, wd:32'h0,        exp:32'h12345678};
        vecs[9]  = '{rd:0, wr:1, addr:8'hEC, wd:32'hFFFFFFFF, exp:32'h0};
        vecs[10] = '{rd:1, wr:0, addr:8'hEC, wd:32'h0,        exp:32'hFFFFFFFF};
        vecs[11] = '{rd:0, wr:1, addr:8'h00, wd:32'h00000000, exp:32'h0};
        vecs[12] = '{rd:1, wr:0, addr:8'h00, wd:32'h0,        exp:32'h00000000};
        vecs[13] = '{rd:0, wr:1, addr:8'h00, wd:32'h00000077, exp:32'h0};

        bus.memread_i   = 1'b0;
        bus.memwrite_i  = 1'b0;
        bus.memaddr_i   = 8'h00;
        bus.memwdata_i  = 32'h0;
        bus.con_ready_i = 1'b0;
        rst = 1'b1;
        do_reset(1'b0, 8'h00, 32'h0, 1'b0);

        foreach (vecs[i]) begin
            do_cycle(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, 1'b0, 1'b1, vecs[i].exp);
        end
        rd_a(8'h00);
        check("ram_after_hold", bus.memrdata_o, 32'h00000077);

        // Misaligned read returns the containing word and latches the flag
        rd_a(8'h13);
        check("misalign_data", bus.memrdata_o, 32'hDEADBEEF);
        check("misalign_flag", {31'b0, bus.misalign_o}, 32'h1);
        idle(1'b0);
        idle(1'b0);
        do_reset(1'b0, 8'h00, 32'h0, 1'b0);
        wr_a(8'h22, 32'h0BADF00D, 1'b0);
        rd_a(8'h20);
        check("misalign_write_data", bus.memrdata_o, 32'h0BADF00D);

`ifdef MEM_MMIO_EN
        do_reset(1'b0, 8'h00, 32'h0, 1'b0);
        rd_a(8'hF8);
        check("cnt_after_reset", bus.memrdata_o, 32'h0);
        rd_a(8'hF8);
        check("cnt_second", bus.memrdata_o, 32'h1);

        wr_a(8'hF0, 32'h41, 1'b0);
        wr_a(8'hF0, 32'h42, 1'b0);
        check("con_head_41", {24'b0, bus.con_data_o}, 32'h41);
        rd_a(8'hF4);
        check("stat_count2", bus.memrdata_o, 32'h00000002);
        idle(1'b1);
        check("con_head_42", {24'b0, bus.con_data_o}, 32'h42);
        idle(1'b1);
        check("con_drained", {31'b0, bus.con_valid_o}, 32'h0);
        idle(1'b1);

        for (int i = 0; i < 5; i++) wr_a(8'hF0, 32'h50 + i, 1'b0);
        rd_a(8'hF4);
        check("stat_ovf", bus.memrdata_o, 32'h000000C4);
        rd_a(8'hF4);
        check("stat_ovf_cleared", bus.memrdata_o, 32'h00000044);

        wr_a(8'hF0, 32'h60, 1'b1);
        rd_a(8'hF4);
        check("push_full_with_pop", bus.memrdata_o, 32'h00000044);
        for (int i = 0; i < 5; i++) idle(1'b1);

        wr_a(8'hF0, 32'h70, 1'b1);
        check("empty_push_no_bypass", {24'b0, bus.con_data_o}, 32'h70);
        idle(1'b1);
        idle(1'b1);

        do_cycle(1'b1, 1'b1, 8'hFC, 32'h12345678, 1'b0, 1'b0, 32'h0);
        rd_a(8'hF0);
        check("tx_read_zero", bus.memrdata_o, 32'h0);
        rd_a(8'hFC);

        wr_a(8'hF8, 32'hFFFFFFFE, 1'b0);
        rd_a(8'hF8);
        check("cnt_loaded", bus.memrdata_o, 32'hFFFFFFFE);
        rd_a(8'hF8);
        rd_a(8'hF8);
        check("cnt_wrap", bus.memrdata_o, 32'h0);
        rd_a(8'hF8);

        wr_a(8'hF0, 32'h80, 1'b0);
        wr_a(8'hF0, 32'h81, 1'b0);
        idle(1'b1);
        do_reset(1'b1, 8'hF0, 32'h99, 1'b1);
        idle(1'b1);
        rd_a(8'hF4);
        check("stat_after_reset", bus.memrdata_o, 32'h00000020);
`else
        wr_a(8'hF0, 32'hCAFEF00D, 1'b1);
        wr_a(8'hFC, 32'h00C0FFEE, 1'b1);
        rd_a(8'hF0);
        check("ram_at_f0", bus.memrdata_o, 32'hCAFEF00D);
        rd_a(8'hFC);
        check("ram_at_fc", bus.memrdata_o, 32'h00C0FFEE);
        idle(1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
